// File: rtl/dnn_accel_pkg.sv
// Shared definitions for the DNN dot-product accelerator: FSM states,
// CSR word offsets and default datapath widths.
package dnn_accel_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 16;
    localparam int DEF_LEN_W  = 16;

    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_BIAS   = 3'd1;
    localparam logic [2:0] CSR_W      = 3'd2;
    localparam logic [2:0] CSR_X      = 3'd3;
    localparam logic [2:0] CSR_OUT    = 3'd4;
    localparam logic [2:0] CSR_LEN    = 3'd5;
    localparam logic [2:0] CSR_RESULT = 3'd6;
    localparam logic [2:0] CSR_MODE   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_BIAS,
        ST_RD_W,
        ST_RD_X,
        ST_MAC,
        ST_WR_OUT
    } state_t;

endpackage

// File: rtl/dnn_fx_mac.sv
// Fixed-point multiply-accumulate: combinational signed Q-format product,
// registered wrap-around accumulator with a load port for initialisation.
module dnn_fx_mac
    import dnn_accel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              mac_en,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] acc_next
);

    logic signed [2*DATA_W-1:0] product;
    logic        [DATA_W-1:0]   prod_q;

    // Full-width signed product, then realign to the Q format by dropping FRAC_W LSBs
    assign product  = (2*DATA_W)'($signed(w)) * (2*DATA_W)'($signed(x));
    assign prod_q   = DATA_W'(product >>> FRAC_W);
    assign acc_next = acc + prod_q;

    // Accumulator: load has priority over accumulate
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (mac_en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/dnn_dot_accel.sv
// Dot-product engine: out = bias + sum(w[i]*x[i]), fetched and written back
// over an Avalon-MM master, programmed through an Avalon-MM CSR slave.
// Optional feature macro: DNN_RELU_EN (adds MODE[0] relu clamp on the output).
module dnn_dot_accel
    import dnn_accel_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [2:0]        slave_address,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [DATA_W-1:0] slave_writedata,
    output logic [DATA_W-1:0] slave_readdata,
    output logic [ADDR_W-1:0] master_address,
    output logic              master_read,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    input  logic              master_waitrequest,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

    state_t            state;
    logic [ADDR_W-1:0] bias_addr, w_addr, x_addr, out_addr;
    logic [ADDR_W-1:0] w_ptr, x_ptr, out_ptr;
    logic [LEN_W-1:0]  len, cnt;
    logic [DATA_W-1:0] result, w_reg, x_reg, acc, acc_next, csr_rdata;
    logic              done, busy, start, cfg_we, relu_en;
    logic              mac_load, mac_en;
    logic [DATA_W-1:0] mac_load_val;

    assign busy   = (state != ST_IDLE);
    assign start  = slave_write && (slave_address == CSR_CTRL) && !busy;
    assign cfg_we = slave_write && !busy;
    assign irq    = done;

    // Accumulator is cleared on start and then loaded with the bias word
    assign mac_load     = start || (state == ST_RD_BIAS && !master_read && master_readdatavalid);
    assign mac_load_val = (state == ST_RD_BIAS) ? master_readdata : '0;
    assign mac_en       = (state == ST_MAC);

    function automatic logic [DATA_W-1:0] apply_relu(input logic [DATA_W-1:0] v, input logic en);
        return (en && v[DATA_W-1]) ? '0 : v;
    endfunction

    dnn_fx_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .load     (mac_load),
        .load_val (mac_load_val),
        .mac_en   (mac_en),
        .w        (w_reg),
        .x        (x_reg),
        .acc      (acc),
        .acc_next (acc_next)
    );

`ifdef DNN_RELU_EN
    // MODE register: relu enable, frozen while a run is in flight
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            relu_en <= 1'b0;
        end else if (cfg_we && slave_address == CSR_MODE) begin
            relu_en <= slave_writedata[0];
        end
    end
`else
    assign relu_en = 1'b0;
`endif

    // CSR read mux
    always_comb begin
        // NOTE: default assignment first so every path drives csr_rdata and
        // no latch is inferred.
        csr_rdata = '0;
        case (slave_address)
            CSR_CTRL:   csr_rdata = {{(DATA_W-2){1'b0}}, busy, done};
            CSR_BIAS:   csr_rdata = DATA_W'(bias_addr);
            CSR_W:      csr_rdata = DATA_W'(w_addr);
            CSR_X:      csr_rdata = DATA_W'(x_addr);
            CSR_OUT:    csr_rdata = DATA_W'(out_addr);
            CSR_LEN:    csr_rdata = DATA_W'(len);
            CSR_RESULT: csr_rdata = result;
            CSR_MODE:   csr_rdata = DATA_W'(relu_en);
            default:    csr_rdata = '0;
        endcase
    end

    // CSR writes, registered read data and the done/irq flag
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            bias_addr      <= '0;
            w_addr         <= '0;
            x_addr         <= '0;
            out_addr       <= '0;
            len            <= '0;
            done           <= 1'b0;
            slave_readdata <= '0;
        end else begin
            if (cfg_we) begin
                case (slave_address)
                    CSR_BIAS: bias_addr <= ADDR_W'(slave_writedata);
                    CSR_W:    w_addr    <= ADDR_W'(slave_writedata);
                    CSR_X:    x_addr    <= ADDR_W'(slave_writedata);
                    CSR_OUT:  out_addr  <= ADDR_W'(slave_writedata);
                    CSR_LEN:  len       <= slave_writedata[LEN_W-1:0];
                    default:  ;
                endcase
            end
            // Completion wins over a same-cycle clear; that read returned the old status
            if (state == ST_WR_OUT && !master_waitrequest) begin
                done <= 1'b1;
            end else if (start || (slave_read && slave_address == CSR_CTRL)) begin
                done <= 1'b0;
            end
            if (slave_read) begin
                slave_readdata <= csr_rdata;
            end
        end
    end

    // Sequencer: one outstanding read; master_read high means "request not yet accepted"
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state            <= ST_IDLE;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_address   <= '0;
            master_writedata <= '0;
            w_ptr            <= '0;
            x_ptr            <= '0;
            out_ptr          <= '0;
            cnt              <= '0;
            w_reg            <= '0;
            x_reg            <= '0;
            result           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        master_read    <= 1'b1;
                        master_address <= bias_addr;
                        w_ptr          <= w_addr;
                        x_ptr          <= x_addr;
                        out_ptr        <= out_addr;
                        cnt            <= len;
                        state          <= ST_RD_BIAS;
                    end
                end
                ST_RD_BIAS: begin
                    if (master_read) begin
                        if (!master_waitrequest) master_read <= 1'b0;
                    end else if (master_readdatavalid) begin
                        if (cnt == '0) begin
                            master_write     <= 1'b1;
                            master_address   <= out_ptr;
                            master_writedata <= apply_relu(master_readdata, relu_en);
                            state            <= ST_WR_OUT;
                        end else begin
                            master_read    <= 1'b1;
                            master_address <= w_ptr;
                            state          <= ST_RD_W;
                        end
                    end
                end
                ST_RD_W: begin
                    if (master_read) begin
                        if (!master_waitrequest) begin
                            master_read <= 1'b0;
                            w_ptr       <= w_ptr + WORD_BYTES;
                        end
                    end else if (master_readdatavalid) begin
                        w_reg          <= master_readdata;
                        master_read    <= 1'b1;
                        master_address <= x_ptr;
                        state          <= ST_RD_X;
                    end
                end
                ST_RD_X: begin
                    if (master_read) begin
                        if (!master_waitrequest) begin
                            master_read <= 1'b0;
                            x_ptr       <= x_ptr + WORD_BYTES;
                        end
                    end else if (master_readdatavalid) begin
                        x_reg <= master_readdata;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    cnt <= cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) begin
                        master_write     <= 1'b1;
                        master_address   <= out_ptr;
                        master_writedata <= apply_relu(acc_next, relu_en);
                        state            <= ST_WR_OUT;
                    end else begin
                        master_read    <= 1'b1;
                        master_address <= w_ptr;
                        state          <= ST_RD_W;
                    end
                end
                ST_WR_OUT: begin
                    if (!master_waitrequest) begin
                        master_write <= 1'b0;
                        result       <= master_writedata;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dnn_dot_accel.sv
// Self-checking bench for dnn_dot_accel: SDRAM fabric model with optional
// random stalls/latency, expected write-backs queued at start, compared on write.
module tb_dnn_dot_accel;

    localparam logic [31:0] BIAS_A = 32'h0000_0100;
    localparam logic [31:0] W_A    = 32'h0000_1000;
    localparam logic [31:0] X_A    = 32'h0000_2000;
    localparam logic [31:0] OUT_A  = 32'h0000_3000;

`ifdef DNN_RELU_EN
    localparam bit RELU_BUILD = 1'b1;
`else
    localparam bit RELU_BUILD = 1'b0;
`endif

    logic        clk_clk, reset_reset_n;
    logic [2:0]  slave_address;
    logic        slave_read, slave_write;
    logic [31:0] slave_writedata, slave_readdata;
    logic [31:0] master_address, master_writedata, master_readdata;
    logic        master_read, master_write, master_readdatavalid, master_waitrequest;
    logic        irq;

    dnn_dot_accel dut (
        .clk_clk              (clk_clk),
        .reset_reset_n        (reset_reset_n),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .slave_readdata       (slave_readdata),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_waitrequest   (master_waitrequest),
        .irq                  (irq)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem [0:4095];
    logic [31:0] wv [0:15];
    logic [31:0] xv [0:15];
    int          tests = 0;
    int          fails = 0;
    int          rd_count = 0;
    int          wr_count = 0;
    bit          rand_fabric = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: Q16.16 products truncated to bits [47:16], wrap-around sum onto bias
    function automatic logic [31:0] dot_model(input logic [31:0] bias, input int n, input bit relu);
        logic [31:0]        acc;
        logic signed [63:0] p;
        acc = bias;
        for (int i = 0; i < n; i++) begin
            p   = $signed(wv[i]) * $signed(xv[i]);
            acc = acc + p[47:16];
        end
        if (relu && acc[31]) acc = 32'h0;
        return acc;
    endfunction

    // SDRAM fabric: decisions made on the falling edge, seen by the DUT on the next rising edge
    initial begin
        logic        pend;
        int          dly;
        logic [31:0] paddr;
        logic        prev_st;
        logic [31:0] prev_a;
        wr_t         e;
        pend = 1'b0; dly = 0; paddr = '0; prev_st = 1'b0; prev_a = '0;
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        forever begin
            @(negedge clk_clk);
            if (!reset_reset_n) begin
                pend = 1'b0;
                prev_st = 1'b0;
                master_waitrequest   = 1'b0;
                master_readdatavalid = 1'b0;
            end else begin
                master_readdatavalid = 1'b0;
                if (pend) begin
                    if (dly == 0) begin
                        master_readdatavalid = 1'b1;
                        master_readdata      = mem[paddr[13:2]];
                        pend = 1'b0;
                    end else begin
                        dly--;
                    end
                end
                if (prev_st) begin
                    check("rd_hold_req", 32'(master_read), 32'd1);
                    check("rd_hold_addr", master_address, prev_a);
                end
                master_waitrequest = rand_fabric ? ($urandom_range(0, 1) == 1) : 1'b0;
                if (master_read && !master_waitrequest) begin
                    pend  = 1'b1;
                    dly   = rand_fabric ? int'($urandom_range(0, 5)) : 0;
                    paddr = master_address;
                    rd_count++;
                end
                if (master_write && !master_waitrequest) begin
                    wr_count++;
                    mem[master_address[13:2]] = master_writedata;
                    if (exp_q.size() == 0) begin
                        check("wr_unexpected_addr", master_address, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", master_address, e.addr);
                        check("wr_data", master_writedata, e.data);
                    end
                end
                prev_st = master_read && master_waitrequest;
                prev_a  = master_address;
            end
        end
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        tick();
        slave_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        slave_address = a;
        slave_read    = 1'b1;
        tick();
        slave_read    = 1'b0;
        d = slave_readdata;
    endtask

    task automatic start_run(input logic [31:0] bias, input int n, input bit relu);
        wr_t e;
        mem[BIAS_A >> 2] = bias;
        for (int i = 0; i < n; i++) begin
            mem[(W_A >> 2) + i] = wv[i];
            mem[(X_A >> 2) + i] = xv[i];
        end
        csr_write(3'd1, BIAS_A);
        csr_write(3'd2, W_A);
        csr_write(3'd3, X_A);
        csr_write(3'd4, OUT_A);
        csr_write(3'd5, 32'(n));
        e.addr = OUT_A;
        e.data = dot_model(bias, n, relu);
        exp_q.push_back(e);
        csr_write(3'd0, 32'h1);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!irq && k < budget) begin
            tick();
            k++;
        end
        check("done_timeout", 32'(irq), 32'd1);
    endtask

    task automatic load_case1();
        wv[0] = 32'h0001_0000; xv[0] = 32'h0002_0000;   //  1.0 * 2.0
        wv[1] = 32'h0002_0000; xv[1] = 32'h0000_8000;   //  2.0 * 0.5
        wv[2] = 32'hFFFF_8000; xv[2] = 32'h0004_0000;   // -0.5 * 4.0
    endtask

    initial begin
        logic [31:0] r;
        int          wr_before;
        int          k;
        reset_reset_n   = 1'b0;
        slave_address   = '0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (3) tick();

        // Reset state
        check("rst_master_read", 32'(master_read), 32'd0);
        check("rst_master_write", 32'(master_write), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_readdata", slave_readdata, 32'd0);
        reset_reset_n = 1'b1;
        tick();
        csr_read(3'd0, r); check("rst_status", r, 32'd0);
        csr_read(3'd6, r); check("rst_result", r, 32'd0);
        csr_read(3'd5, r); check("rst_len", r, 32'd0);

        // Case 1: 1.0 + 2.0 + 1.0 - 2.0 = 2.0
        load_case1();
        rd_count = 0;
        start_run(32'h0001_0000, 3, 1'b0);
        wait_done(500);
        check("t1_pending_writes", exp_q.size(), 32'd0);
        check("t1_irq", 32'(irq), 32'd1);
        csr_read(3'd6, r); check("t1_result", r, 32'h0002_0000);
        check("t1_reads", rd_count, 32'd7);
        csr_read(3'd0, r); check("t1_status_done", r, 32'd1);
        check("t1_irq_cleared", 32'(irq), 32'd0);

        // Case 2: LEN=0 writes the bias only
        rd_count = 0;
        start_run(32'hFFFF_8000, 0, 1'b0);
        wait_done(200);
        check("t2_reads", rd_count, 32'd1);
        csr_read(3'd6, r); check("t2_result", r, 32'hFFFF_8000);

        // Case 4: MODE/relu, behaviour depends on the build
        csr_write(3'd7, 32'h1);
        csr_read(3'd7, r); check("t4_mode", r, 32'(RELU_BUILD));
        start_run(32'hFFFF_8000, 0, RELU_BUILD);
        wait_done(200);
        csr_read(3'd6, r); check("t4_result", r, RELU_BUILD ? 32'h0 : 32'hFFFF_8000);
        csr_write(3'd7, 32'h0);

        // Case 3: random stalls and latency, LEN=16
        rand_fabric = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wv[i] = $urandom;
            xv[i] = $urandom;
        end
        start_run($urandom, 16, 1'b0);
        wait_done(3000);
        check("t3_pending_writes", exp_q.size(), 32'd0);

        // Case 5: start and W_ADDR write while busy are ignored; read-to-clear of done
        for (int i = 0; i < 4; i++) begin
            wv[i] = $urandom;
            xv[i] = $urandom;
        end
        wr_before = wr_count;
        start_run(32'h0000_4000, 4, 1'b0);
        csr_read(3'd0, r); check("t5_status_busy", r, 32'd2);
        csr_write(3'd2, 32'h0000_1800);
        csr_write(3'd0, 32'h1);
        csr_read(3'd2, r); check("t5_waddr_kept", r, W_A);
        wait_done(2000);
        check("t5_irq", 32'(irq), 32'd1);
        csr_read(3'd0, r); check("t5_status_done", r, 32'd1);
        check("t5_irq_cleared", 32'(irq), 32'd0);
        csr_read(3'd0, r); check("t5_status_idle", r, 32'd0);
        repeat (20) tick();
        check("t5_write_count", wr_count - wr_before, 32'd1);
        rand_fabric = 1'b0;

        // Case 6: reset while an activation read is outstanding, then a clean rerun
        load_case1();
        start_run(32'h0001_0000, 3, 1'b0);
        k = 0;
        while (!(master_read && master_address >= X_A && master_address < X_A + 32'h100) && k < 200) begin
            tick();
            k++;
        end
        check("t6_reached_rd_x", 32'(master_read), 32'd1);
        reset_reset_n = 1'b0;
        exp_q.delete();
        tick();
        check("t6_read_dropped", 32'(master_read), 32'd0);
        check("t6_write_low", 32'(master_write), 32'd0);
        tick();
        reset_reset_n = 1'b1;
        tick();
        csr_read(3'd0, r); check("t6_status", r, 32'd0);
        start_run(32'h0001_0000, 3, 1'b0);
        wait_done(500);
        csr_read(3'd6, r); check("t6_result", r, 32'h0002_0000);
        check("t6_pending_writes", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule
